// File: rtl/seg7_scan_driver_pkg.sv
// Shared code values, segment patterns and scan FSM states for the 4-digit
// multiplexed 7-segment driver. Patterns are active-low {g,f,e,d,c,b,a}.
package seg7_scan_driver_pkg;

  localparam logic [4:0] CODE_UNDERSCORE = 5'h1F;
  localparam logic [4:0] CODE_BLANK      = 5'd10;

  localparam logic [6:0] SEG_0          = 7'b1000000;
  localparam logic [6:0] SEG_1          = 7'b1111001;
  localparam logic [6:0] SEG_2          = 7'b0100100;
  localparam logic [6:0] SEG_3          = 7'b0110000;
  localparam logic [6:0] SEG_4          = 7'b0011001;
  localparam logic [6:0] SEG_5          = 7'b0010010;
  localparam logic [6:0] SEG_6          = 7'b0000010;
  localparam logic [6:0] SEG_7          = 7'b1111000;
  localparam logic [6:0] SEG_8          = 7'b0000000;
  localparam logic [6:0] SEG_9          = 7'b0010000;
  localparam logic [6:0] SEG_UNDERSCORE = 7'b1110111;
  localparam logic [6:0] SEG_OFF        = 7'b1111111;

  typedef enum logic {
    ST_INIT,
    ST_SCAN
  } scan_state_e;

endpackage

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// Combinational digit-code decoder: 0-9 digits, 5'h1F underscore, all else blank.
module bcd_to_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [4:0] i_code,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_OFF;
    case (i_code)
      5'd0:            o_seg = SEG_0;
      5'd1:            o_seg = SEG_1;
      5'd2:            o_seg = SEG_2;
      5'd3:            o_seg = SEG_3;
      5'd4:            o_seg = SEG_4;
      5'd5:            o_seg = SEG_5;
      5'd6:            o_seg = SEG_6;
      5'd7:            o_seg = SEG_7;
      5'd8:            o_seg = SEG_8;
      5'd9:            o_seg = SEG_9;
      CODE_UNDERSCORE: o_seg = SEG_UNDERSCORE;
      default:         o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed 7-segment scan driver with per-frame input snapshot,
// anti-ghosting blank window, optional leading-zero blanking and registered pins.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 4,
  parameter bit          LZB          = 1'b0
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic [4:0] bcd3,
  input  logic [4:0] bcd2,
  input  logic [4:0] bcd1,
  input  logic [4:0] bcd0,
  input  logic       si,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned   PW         = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);

  scan_state_e     r_state;
  scan_state_e     w_state_nxt;
  logic [PW-1:0]   r_presc;
  logic [1:0]      r_slot;
  logic [3:0][4:0] r_snap;
  logic            r_snap_si;
  logic            w_wrap;
  logic            w_capture;
  logic            w_lit;
  logic [3:0]      w_lead_zero;
  logic [4:0]      w_code;
  logic [6:0]      w_seg;

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) r_state <= ST_INIT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_INIT) w_state_nxt = ST_SCAN;
  end

  assign w_wrap    = (r_state == ST_SCAN) && (r_presc == PRESC_LAST);
  assign w_capture = (r_state == ST_INIT) || (w_wrap && (r_slot == 2'd3));

  // Prescaler is held at 0 during INIT so slot 0 starts on the first SCAN cycle.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
      r_slot  <= '0;
    end else if (r_state == ST_SCAN) begin
      if (w_wrap) begin
        r_presc <= '0;
        r_slot  <= r_slot + 2'd1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      r_snap    <= {4{CODE_BLANK}};
      r_snap_si <= 1'b0;
    end else if (w_capture) begin
      r_snap    <= {bcd3, bcd2, bcd1, bcd0};
      r_snap_si <= si;
    end
  end

  // w_lead_zero[k]: digit k and every digit to its left are 0; digit 0 never blanks.
  always_comb begin
    w_lead_zero    = '0;
    w_lead_zero[3] = (r_snap[3] == 5'd0);
    w_lead_zero[2] = w_lead_zero[3] && (r_snap[2] == 5'd0);
    w_lead_zero[1] = w_lead_zero[2] && (r_snap[1] == 5'd0);
  end

  assign w_code = (LZB && w_lead_zero[r_slot]) ? CODE_BLANK : r_snap[r_slot];
  assign w_lit  = (r_state == ST_SCAN) && (r_presc >= BLANK_END);

  bcd_to_seg7 u_dec (
    .i_code (w_code),
    .o_seg  (w_seg)
  );

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      an  <= '1;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= w_lit ? ~(4'b0001 << r_slot) : '1;
      seg <= w_lit ? w_seg : SEG_OFF;
      dp  <= ~(w_lit && (r_slot == 2'd0) && r_snap_si);
    end
  end

endmodule
